// File: rtl/tlb_entry_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_entry_writer
//  Description : Snapshots the TLB CSRs on TLBWR/TLBFILL commit and drives
//                one formatted entry write into the TLB array.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlb_entry_writer #(
    parameter int TLB_NUM = 16,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tlbwr_req,
    input  logic              tlbfill_req,
    input  logic [31:0]       csr_tlbidx,
    input  logic [31:0]       csr_tlbehi,
    input  logic [31:0]       csr_tlbelo0,
    input  logic [31:0]       csr_tlbelo1,
    input  logic [9:0]        csr_asid,
    input  logic [5:0]        csr_estat_ecode,
    input  logic              tlb_w_ready,
    output logic              busy,
    output logic              done,
    output logic              tlb_we,
    output logic [IDX_W-1:0]  tlb_w_index,
    output logic              tlb_w_e,
    output logic [18:0]       tlb_w_vppn,
    output logic [5:0]        tlb_w_ps,
    output logic [9:0]        tlb_w_asid,
    output logic              tlb_w_g,
    output logic [19:0]       tlb_w_ppn0,
    output logic [19:0]       tlb_w_ppn1,
    output logic [1:0]        tlb_w_plv0,
    output logic [1:0]        tlb_w_plv1,
    output logic [1:0]        tlb_w_mat0,
    output logic [1:0]        tlb_w_mat1,
    output logic              tlb_w_d0,
    output logic              tlb_w_d1,
    output logic              tlb_w_v0,
    output logic              tlb_w_v1
);

    localparam logic [5:0]       C_ECODE_TLBR = 6'h3F;
    localparam logic [IDX_W-1:0] C_FILL_LAST  = IDX_W'(TLB_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_fill_cnt;
    logic             w_capture;

    // Bits of the CSRs that are not part of a TLB entry.
    logic w_unused;
    assign w_unused = ^{csr_tlbidx[30], csr_tlbidx[23:IDX_W], csr_tlbehi[12:0],
                        csr_tlbelo0[31:28], csr_tlbelo0[7],
                        csr_tlbelo1[31:28], csr_tlbelo1[7]};

    assign w_capture = (r_state == ST_IDLE) && (tlbwr_req || tlbfill_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (tlbwr_req || tlbfill_req) w_state_nxt = ST_WRITE;
            ST_WRITE: if (tlb_w_ready)              w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Round-robin victim pointer for TLBFILL, free-running in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_cnt <= '0;
        end else if (r_fill_cnt == C_FILL_LAST) begin
            r_fill_cnt <= '0;
        end else begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tlb_w_index <= '0;
            tlb_w_e     <= 1'b0;
            tlb_w_vppn  <= '0;
            tlb_w_ps    <= '0;
            tlb_w_asid  <= '0;
            tlb_w_g     <= 1'b0;
            tlb_w_ppn0  <= '0;
            tlb_w_ppn1  <= '0;
            tlb_w_plv0  <= '0;
            tlb_w_plv1  <= '0;
            tlb_w_mat0  <= '0;
            tlb_w_mat1  <= '0;
            tlb_w_d0    <= 1'b0;
            tlb_w_d1    <= 1'b0;
            tlb_w_v0    <= 1'b0;
            tlb_w_v1    <= 1'b0;
        end else if (w_capture) begin
            // TLBWR wins when both commit together.
            tlb_w_index <= tlbwr_req ? csr_tlbidx[IDX_W-1:0] : r_fill_cnt;
            tlb_w_e     <= (csr_estat_ecode == C_ECODE_TLBR) ? 1'b1 : ~csr_tlbidx[31];
            tlb_w_vppn  <= csr_tlbehi[31:13];
            tlb_w_ps    <= csr_tlbidx[29:24];
            tlb_w_asid  <= csr_asid;
            tlb_w_g     <= csr_tlbelo0[6] & csr_tlbelo1[6];
            tlb_w_ppn0  <= csr_tlbelo0[27:8];
            tlb_w_ppn1  <= csr_tlbelo1[27:8];
            tlb_w_plv0  <= csr_tlbelo0[3:2];
            tlb_w_plv1  <= csr_tlbelo1[3:2];
            tlb_w_mat0  <= csr_tlbelo0[5:4];
            tlb_w_mat1  <= csr_tlbelo1[5:4];
            tlb_w_d0    <= csr_tlbelo0[1];
            tlb_w_d1    <= csr_tlbelo1[1];
            tlb_w_v0    <= csr_tlbelo0[0];
            tlb_w_v1    <= csr_tlbelo1[0];
        end
    end

    assign tlb_we = (r_state == ST_WRITE);
    assign done   = (r_state == ST_DONE);
    assign busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tlb_entry_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlb_entry_writer
//  Description : Directed vector bench for tlb_entry_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_entry_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        tlbwr_req, tlbfill_req;
    logic [31:0] csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1;
    logic [9:0]  csr_asid;
    logic [5:0]  csr_estat_ecode;
    logic        tlb_w_ready;
    logic        busy, done, tlb_we;
    logic [3:0]  tlb_w_index;
    logic        tlb_w_e, tlb_w_g;
    logic [18:0] tlb_w_vppn;
    logic [5:0]  tlb_w_ps;
    logic [9:0]  tlb_w_asid;
    logic [19:0] tlb_w_ppn0, tlb_w_ppn1;
    logic [1:0]  tlb_w_plv0, tlb_w_plv1, tlb_w_mat0, tlb_w_mat1;
    logic        tlb_w_d0, tlb_w_d1, tlb_w_v0, tlb_w_v1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tlb_entry_writer #(.TLB_NUM(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .tlbwr_req(tlbwr_req), .tlbfill_req(tlbfill_req),
        .csr_tlbidx(csr_tlbidx), .csr_tlbehi(csr_tlbehi),
        .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1),
        .csr_asid(csr_asid), .csr_estat_ecode(csr_estat_ecode),
        .tlb_w_ready(tlb_w_ready),
        .busy(busy), .done(done), .tlb_we(tlb_we),
        .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn),
        .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g),
        .tlb_w_ppn0(tlb_w_ppn0), .tlb_w_ppn1(tlb_w_ppn1),
        .tlb_w_plv0(tlb_w_plv0), .tlb_w_plv1(tlb_w_plv1),
        .tlb_w_mat0(tlb_w_mat0), .tlb_w_mat1(tlb_w_mat1),
        .tlb_w_d0(tlb_w_d0), .tlb_w_d1(tlb_w_d1),
        .tlb_w_v0(tlb_w_v0), .tlb_w_v1(tlb_w_v1)
    );

    typedef struct {
        logic        wr;
        logic        fill;
        logic [31:0] idx;
        logic [31:0] ehi;
        logic [31:0] elo0;
        logic [31:0] elo1;
        logic [9:0]  asid;
        logic [5:0]  ecode;
        int          stall;
        logic [3:0]  x_index;
        logic        x_e;
        logic [18:0] x_vppn;
        logic [5:0]  x_ps;
        logic        x_g;
        logic [19:0] x_ppn0;
        logic [19:0] x_ppn1;
        logic [1:0]  x_plv0;
        logic [1:0]  x_plv1;
        logic [1:0]  x_mat0;
        logic [1:0]  x_mat1;
        logic        x_d0;
        logic        x_d1;
        logic        x_v0;
        logic        x_v1;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_fields(input string tag, input vec_t v);
        chk({tag, " index"}, 32'(tlb_w_index), 32'(v.x_index));
        chk({tag, " e"},     32'(tlb_w_e),     32'(v.x_e));
        chk({tag, " vppn"},  32'(tlb_w_vppn),  32'(v.x_vppn));
        chk({tag, " ps"},    32'(tlb_w_ps),    32'(v.x_ps));
        chk({tag, " asid"},  32'(tlb_w_asid),  32'(v.asid));
        chk({tag, " g"},     32'(tlb_w_g),     32'(v.x_g));
        chk({tag, " ppn0"},  32'(tlb_w_ppn0),  32'(v.x_ppn0));
        chk({tag, " ppn1"},  32'(tlb_w_ppn1),  32'(v.x_ppn1));
        chk({tag, " plv"},   32'({tlb_w_plv1, tlb_w_plv0}), 32'({v.x_plv1, v.x_plv0}));
        chk({tag, " mat"},   32'({tlb_w_mat1, tlb_w_mat0}), 32'({v.x_mat1, v.x_mat0}));
        chk({tag, " dv"},    32'({tlb_w_d1, tlb_w_d0, tlb_w_v1, tlb_w_v0}),
                             32'({v.x_d1, v.x_d0, v.x_v1, v.x_v0}));
    endtask

    // Runs one write from the cycle before the capture edge to the first idle cycle.
    task automatic run_txn(input string tag, input vec_t v);
        tlbwr_req       = v.wr;
        tlbfill_req     = v.fill;
        csr_tlbidx      = v.idx;
        csr_tlbehi      = v.ehi;
        csr_tlbelo0     = v.elo0;
        csr_tlbelo1     = v.elo1;
        csr_asid        = v.asid;
        csr_estat_ecode = v.ecode;
        tlb_w_ready     = 1'b0;
        step();
        tlbwr_req       = 1'b0;
        tlbfill_req     = 1'b0;
        csr_tlbidx      = ~v.idx;
        csr_tlbehi      = ~v.ehi;
        csr_tlbelo0     = ~v.elo0;
        csr_tlbelo1     = ~v.elo1;
        csr_asid        = ~v.asid;
        csr_estat_ecode = ~v.ecode;
        for (int i = 0; i <= v.stall; i++) begin
            chk({tag, " we"},   32'(tlb_we), 32'd1);
            chk({tag, " done"}, 32'(done),   32'd0);
            chk({tag, " busy"}, 32'(busy),   32'd1);
            chk_fields(tag, v);
            tlb_w_ready = (i == v.stall);
            step();
        end
        tlb_w_ready = 1'b0;
        chk({tag, " done pulse"}, 32'(done),   32'd1);
        chk({tag, " we off"},     32'(tlb_we), 32'd0);
        chk({tag, " busy done"},  32'(busy),   32'd1);
        step();
        chk({tag, " done end"},   32'(done),   32'd0);
        chk({tag, " busy end"},   32'(busy),   32'd0);
    endtask

    function automatic vec_t fill_vec(input logic [3:0] exp_idx);
        vec_t v;
        v = '{wr: 1'b0, fill: 1'b1, idx: 32'h8000_0009, ehi: 32'h0000_4000,
              elo0: 32'h0000_0001, elo1: 32'h0000_0002, asid: 10'h0AA, ecode: 6'h3F,
              stall: 0, x_index: exp_idx, x_e: 1'b1, x_vppn: 19'h2, x_ps: 6'h0,
              x_g: 1'b0, x_ppn0: 20'h0, x_ppn1: 20'h0, x_plv0: 2'd0, x_plv1: 2'd0,
              x_mat0: 2'd0, x_mat1: 2'd0, x_d0: 1'b0, x_d1: 1'b1, x_v0: 1'b1, x_v1: 1'b0};
        return v;
    endfunction

    initial begin
        // Basic TLBWR with elo1.G clear.
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0005, 32'h2468_A000, 32'h0ABC_DE5F, 32'h0135_7929,
                    10'h155, 6'h00, 0,
                    4'h5, 1'b1, 19'h12345, 6'h00, 1'b0, 20'hABCDE, 20'h13579,
                    2'd3, 2'd2, 2'd1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1};
        // Three stall cycles, all-ones fields, both G set.
        vecs[1] = '{1'b1, 1'b0, 32'h0C00_000A, 32'hFFFF_E000, 32'hFFFF_FFFF, 32'h0000_0040,
                    10'h3FF, 6'h05, 3,
                    4'hA, 1'b1, 19'h7FFFF, 6'h0C, 1'b1, 20'hFFFFF, 20'h00000,
                    2'd3, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        // NE=1 with refill ecode keeps the entry.
        vecs[2] = '{1'b1, 1'b0, 32'h8000_0003, 32'h0, 32'h0, 32'h0, 10'h000, 6'h3F, 0,
                    4'h3, 1'b1, 19'h0, 6'h00, 1'b0, 20'h0, 20'h0,
                    2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        // NE=1 with ordinary ecode clears E.
        vecs[3] = '{1'b1, 1'b0, 32'h8000_0004, 32'h0, 32'h0, 32'h0, 10'h000, 6'h00, 0,
                    4'h4, 1'b0, 19'h0, 6'h00, 1'b0, 20'h0, 20'h0,
                    2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        // Both requests: TLBWR index wins.
        vecs[4] = '{1'b1, 1'b1, 32'h1500_0007, 32'h0000_2000, 32'h0000_0100, 32'h0800_0000,
                    10'h001, 6'h00, 0,
                    4'h7, 1'b1, 19'h00001, 6'h15, 1'b0, 20'h00001, 20'h80000,
                    2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        // Top index, upper index bits ignored, one stall.
        vecs[5] = '{1'b1, 1'b0, 32'h0000_00FF, 32'h0, 32'h0, 32'h0, 10'h200, 6'h3E, 1,
                    4'hF, 1'b1, 19'h0, 6'h00, 1'b0, 20'h0, 20'h0,
                    2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        tlbwr_req = 1'b0; tlbfill_req = 1'b0;
        csr_tlbidx = '0; csr_tlbehi = '0; csr_tlbelo0 = '0; csr_tlbelo1 = '0;
        csr_asid = '0; csr_estat_ecode = '0; tlb_w_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset busy", 32'(busy),   32'd0);
        chk("reset done", 32'(done),   32'd0);
        chk("reset we",   32'(tlb_we), 32'd0);
        chk("reset fields", 32'({tlb_w_index, tlb_w_e, tlb_w_g, tlb_w_ps, tlb_w_asid}), 32'd0);
        chk("reset ppn", 32'(tlb_w_ppn0 | tlb_w_ppn1 | 20'(tlb_w_vppn)), 32'd0);

        // Fill counter: 10 idle edges, capture sees 10; 17 edges later sees 11.
        repeat (10) step();
        run_txn("fill1", fill_vec(4'd10));
        repeat (14) step();
        run_txn("fill2", fill_vec(4'd11));

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while stalled in WRITE.
        tlbwr_req = 1'b1; csr_tlbidx = 32'h0000_0006; csr_tlbehi = 32'hFFFF_E000;
        tlb_w_ready = 1'b0;
        step();
        tlbwr_req = 1'b0;
        chk("rstw we before", 32'(tlb_we), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw we",   32'(tlb_we),     32'd0);
        chk("rstw done", 32'(done),       32'd0);
        chk("rstw busy", 32'(busy),       32'd0);
        chk("rstw vppn", 32'(tlb_w_vppn), 32'd0);
        run_txn("rstw fill", fill_vec(4'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlb_entry_writer.md
# tlb_entry_writer

Write-side sequencer for the TLB array. It services TLBWR and TLBFILL at commit: snapshots the TLBEHI, TLBELO0/1, TLBIDX, ASID and ESTAT CSRs and selects the target index (TLBIDX.Index for TLBWR, a free-running round-robin counter for TLBFILL). It then formats the entry and drives one write into the TLB array through a ready handshake. It is the counterpart of the TLBRD path that loads TLB entries back into the TLBELO CSRs.

## Interface
- TLB_NUM, 16, number of TLB entries; must be a power of two.
- IDX_W, 4, log2(TLB_NUM).

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- tlbwr_req  in  1  TLBWR committing this cycle
- tlbfill_req  in  1  TLBFILL committing this cycle
- csr_tlbidx  in  32  TLBIDX: Index[IDX_W-1:0], PS[29:24], NE[31]
- csr_tlbehi  in  32  TLBEHI: VPPN[31:13]
- csr_tlbelo0  in  32  TLBELO0: V[0] D[1] PLV[3:2] MAT[5:4] G[6] PPN[27:8]
- csr_tlbelo1  in  32  TLBELO1, same layout
- csr_asid  in  10  ASID.ASID
- csr_estat_ecode  in  6  ESTAT.Ecode
- tlb_w_ready  in  1  array accepts write this cycle
- busy  out  1  sequencer occupied; commit must stall further TLB writes
- done  out  1  one-cycle pulse after write accepted
- tlb_we  out  1  write request to array
- tlb_w_index  out  IDX_W  target entry
- tlb_w_e  out  1  entry exists bit
- tlb_w_vppn  out  19  VPPN
- tlb_w_ps  out  6  page size
- tlb_w_asid  out  10  ASID
- tlb_w_g  out  1  global = elo0.G & elo1.G
- tlb_w_ppn0, tlb_w_ppn1  out  20  PPN per half
- tlb_w_plv0, tlb_w_plv1  out  2  PLV per half
- tlb_w_mat0, tlb_w_mat1  out  2  MAT per half
- tlb_w_d0, tlb_w_d1, tlb_w_v0, tlb_w_v1  out  1  dirty/valid per half

## Operation
- FSM states: IDLE, WRITE, DONE. Reset → IDLE.
- IDLE: if tlbwr_req or tlbfill_req, latch all fields into holding registers at the edge and go to WRITE. Both asserted → treated as TLBWR (fill counter ignored).
- Index: TLBWR → csr_tlbidx[IDX_W-1:0]; TLBFILL → fill_cnt value at the capturing edge.
- fill_cnt: IDX_W-bit counter, reset 0, +1 every cycle in every state, wraps TLB_NUM-1 → 0.
- E bit: csr_estat_ecode == 6'h3F (TLB refill) → e=1; otherwise e = ~csr_tlbidx[31].
- tlb_w_g = csr_tlbelo0[6] & csr_tlbelo1[6]. Per-half fields are taken straight from the bit positions above.
- WRITE: tlb_we=1. Edge with tlb_w_ready=1 → DONE. Otherwise hold WRITE with all tlb_w_* stable.
- DONE: done=1 for exactly one cycle, then IDLE. Requests arriving in WRITE or DONE are ignored; the commit stage guarantees none while busy=1.
- busy = (state != IDLE).
- rst in any state: next cycle state=IDLE, tlb_we=0, done=0, fill_cnt=0. No partial write is reported.

## Timing
- Reset values: busy=0, done=0, tlb_we=0, all tlb_w_* fields 0, fill_cnt=0.
- tlb_we and done decode combinationally from state. tlb_w_* come from registers.
- Request sampled at edge N → tlb_we high from cycle N+1. With tlb_w_ready=1 in N+1: done high in N+2, busy low in N+3, next request acceptable at edge N+3.
- k cycles of tlb_w_ready=0 add exactly k cycles to tlb_we, done and busy.
- CSR changes after edge N do not affect the written entry.

## Test plan
- TLBWR, tlbidx=0x0000_0005, tlbehi=0x2468_A000, elo0 = PPN 0xABCDE, V=1, D=1, PLV=3, MAT=1, G=1; elo1 G=0, ready=1 → tlb_we only in N+1, index=5, vppn=0x12345, e=1, g=0, ppn0=0xABCDE, plv0=3, mat0=1; done only in N+2.
- Reset, hold idle 10 cycles, then TLBFILL → index = fill_cnt at the capture edge (10 mod 16); repeat 17 cycles later → index advanced by 17 mod 16, confirming wrap.
- TLBWR with tlb_w_ready low 3 cycles → tlb_we high 4 cycles with fields constant, done 1 cycle after ready, busy high 5 cycles total.
- NE=1, ecode=0x3F → e=1; NE=1, ecode=0 → e=0; NE=0 → e=1.
- tlbwr_req and tlbfill_req together with tlbidx index=7 → tlb_w_index=7.
- rst asserted while in WRITE → tlb_we=0 next cycle, no done pulse, busy=0, fill_cnt=0.
